// File: rtl/mem_dump_if.sv
// Bus between mem_dump_streamer and its neighbours: debug command, memory read port, UART TX.
// The streamer connects to the slave modport; the debug/memory/TX side uses master.
interface mem_dump_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_BYTE = 8
);
  logic               i_start;
  logic [NB_ADDR-1:0] i_base_addr;
  logic [NB_ADDR-1:0] i_word_count;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] i_mem_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_start, i_base_addr, i_word_count, i_mem_data, i_tx_done,
    output o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_word_count, i_mem_data, i_tx_done,
    input  o_mem_addr, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/mem_dump_streamer.sv
// Streams 32-bit memory words to the UART TX one byte at a time, MSB first.
// Optional trailing checksum byte when DUMP_CHECKSUM_EN is defined.
module mem_dump_streamer #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_BYTE = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  mem_dump_if.slave  bus,
  output logic [2:0] o_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_ADV   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM  = 3'd6;
  localparam logic [2:0] ST_LAST  = ST_CSUM;
`else
  localparam logic [2:0] ST_LAST  = ST_DONE;
`endif

  logic [2:0]         state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_ADDR-1:0] rem_q, rem_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [1:0]         idx_q, idx_d;
  logic [NB_BYTE-1:0] cur_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] sum_q, sum_d;
  logic               csum_q, csum_d;
`endif

  always_comb begin
    cur_byte = word_q[31:24];
    case (idx_q)
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
  end

  // TX handshake: o_tx_start pulses for the single SEND cycle with o_tx_data valid;
  // o_tx_data holds until the transmitter answers with a one-cycle i_tx_done in WAIT.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    idx_d   = idx_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d   = sum_q;
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          addr_d  = bus.i_base_addr;
          rem_d   = bus.i_word_count;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
          csum_d  = 1'b0;
`endif
          state_d = (bus.i_word_count == '0) ? ST_LAST : ST_LATCH;
        end
      end
      ST_LATCH: begin
        word_d  = bus.i_mem_data;
        idx_d   = 2'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
`ifdef DUMP_CHECKSUM_EN
        if (!csum_q) sum_d = sum_q + cur_byte;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) state_d = ST_ADV;
      end
      ST_ADV: begin
`ifdef DUMP_CHECKSUM_EN
        if (csum_q) begin
          state_d = ST_DONE;
        end else
`endif
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SEND;
        end else begin
          rem_d   = rem_q - NB_ADDR'(1);
          addr_d  = addr_q + NB_ADDR'(4);
          state_d = (rem_q == NB_ADDR'(1)) ? ST_LAST : ST_LATCH;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      // The checksum rides through SEND/WAIT/ADV as a one-byte pseudo word.
      ST_CSUM: begin
        word_d  = {sum_q, 24'd0};
        idx_d   = 2'd0;
        csum_d  = 1'b1;
        state_d = ST_SEND;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= '0;
      csum_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q   <= sum_d;
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.o_mem_addr = addr_q;
  assign bus.o_tx_data  = cur_byte;
  assign bus.o_tx_start = (state_q == ST_SEND);
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = (state_q == ST_DONE);
  assign o_state        = state_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer: expected bytes/addresses are queued at issue time
// and a negedge monitor pops and compares them as the DUT emits.
module tb_mem_dump_streamer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  always #5 clk = ~clk;

  mem_dump_if bus ();

  mem_dump_streamer dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_state (state)
  );

  logic [7:0] mem [256];
  always_comb
    bus.i_mem_data = {mem[bus.o_mem_addr], mem[bus.o_mem_addr + 8'd1],
                      mem[bus.o_mem_addr + 8'd2], mem[bus.o_mem_addr + 8'd3]};

  logic [7:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, start_cnt = 0, txd_cnt = 0;
  logic spurious_en = 1'b0, inject_en = 1'b0;
  logic [7:0] held;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Transmitter model: answers each o_tx_start with i_tx_done 5 cycles later.
  initial begin
    int cnt;
    cnt = 0;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (rst_n !== 1'b1) begin
        cnt = 0;
        continue;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.i_tx_done = 1'b1;
          txd_cnt++;
        end
      end else if (bus.o_tx_start) begin
        cnt = 5;
        if (inject_en) bus.i_tx_done = 1'b1;
      end else if (spurious_en) begin
        bus.i_tx_done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.o_tx_start) begin
          start_cnt++;
          held = bus.o_tx_data;
          if (exp_q.size() == 0) check("unexpected_tx_byte", {24'd0, bus.o_tx_data}, 32'hFFFF_FFFF);
          else check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (state == ST_WAIT && bus.i_tx_done)
          check("tx_data_held", {24'd0, bus.o_tx_data}, {24'd0, held});
        if (state == ST_LATCH) begin
          if (exp_addr_q.size() == 0) check("unexpected_latch", {24'd0, bus.o_mem_addr}, 32'hFFFF_FFFF);
          else check("mem_addr", {24'd0, bus.o_mem_addr}, {24'd0, exp_addr_q.pop_front()});
        end
        if (bus.o_done) done_cnt++;
      end
    end
  end

  task automatic start_dump(input logic [7:0] base, input logic [7:0] count);
    @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_base_addr  = base;
    bus.i_word_count = count;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
    check({name, "_busy_low"}, {31'd0, bus.o_busy}, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_addr_queue_empty"}, exp_addr_q.size(), 0);
  endtask

  task automatic push_bytes(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  initial begin
    int d0, s0, t0;
    bit hit;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_base_addr = '0;
    bus.i_word_count = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'(8'h11 * (i + 1));
    mem[8'hFC] = 8'hA1; mem[8'hFD] = 8'hA2; mem[8'hFE] = 8'hA3; mem[8'hFF] = 8'hA4;
    mem[8'h00] = 8'hB1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hB3; mem[8'h03] = 8'hB4;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("rst_busy", {31'd0, bus.o_busy}, 0);
    check("rst_done", {31'd0, bus.o_done}, 0);
    check("rst_tx_start", {31'd0, bus.o_tx_start}, 0);
    check("rst_mem_addr", {24'd0, bus.o_mem_addr}, 0);
    check("rst_tx_data", {24'd0, bus.o_tx_data}, 0);
    rst_n = 1'b1;
    spurious_en = 1'b1;
    repeat (6) @(negedge clk);
    spurious_en = 1'b0;
    check("idle_tx_done_no_start", start_cnt, 0);
    check("idle_tx_done_state", {29'd0, state}, {29'd0, ST_IDLE});

    // Basic two-word dump with latency checks
    push_bytes(32'h11223344);
    push_bytes(32'h55667788);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h64);
`endif
    exp_addr_q.push_back(8'h10);
    exp_addr_q.push_back(8'h14);
    d0 = done_cnt;
    start_dump(8'h10, 8'd2);
    @(negedge clk);
    check("busy_after_start", {31'd0, bus.o_busy}, 1);
    check("tx_start_not_yet", {31'd0, bus.o_tx_start}, 0);
    @(negedge clk);
    check("first_tx_start_latency", {31'd0, bus.o_tx_start}, 1);
    wait_done("basic");
    check("basic_done_count", done_cnt - d0, 1);

    // Zero-word dump
    d0 = done_cnt;
    s0 = start_cnt;
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h00);
    start_dump(8'h20, 8'd0);
    wait_done("zero");
    check("zero_start_count", start_cnt - s0, 1);
`else
    start_dump(8'h20, 8'd0);
    @(negedge clk);
    check("zero_done_latency", {31'd0, bus.o_done}, 1);
    @(negedge clk);
    check("zero_busy_low", {31'd0, bus.o_busy}, 0);
    check("zero_start_count", start_cnt - s0, 0);
`endif
    check("zero_done_count", done_cnt - d0, 1);

    // Address wrap 0xFC -> 0x00
    push_bytes(32'hA1A2A3A4);
    push_bytes(32'hB1B2B3B4);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h54);
`endif
    exp_addr_q.push_back(8'hFC);
    exp_addr_q.push_back(8'h00);
    d0 = done_cnt;
    start_dump(8'hFC, 8'd2);
    wait_done("wrap");
    check("wrap_done_count", done_cnt - d0, 1);

    // i_start while busy and i_tx_done during SEND are both ignored
    push_bytes(32'h11223344);
    push_bytes(32'h55667788);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h64);
`endif
    exp_addr_q.push_back(8'h10);
    exp_addr_q.push_back(8'h14);
    d0 = done_cnt;
    inject_en = 1'b1;
    start_dump(8'h10, 8'd2);
    repeat (20) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_base_addr = 8'h40;
    bus.i_word_count = 8'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done("ignore");
    inject_en = 1'b0;
    check("ignore_done_count", done_cnt - d0, 1);

    // Reset after the third byte aborts the dump
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_addr_q.push_back(8'h10);
    d0 = done_cnt;
    t0 = txd_cnt;
    start_dump(8'h10, 8'd2);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (txd_cnt >= t0 + 3) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("abort_third_byte_timeout", 0, 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("abort_busy", {31'd0, bus.o_busy}, 0);
    check("abort_tx_start", {31'd0, bus.o_tx_start}, 0);
    check("abort_mem_addr", {24'd0, bus.o_mem_addr}, 0);
    check("abort_tx_data", {24'd0, bus.o_tx_data}, 0);
    check("abort_done", {31'd0, bus.o_done}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_no_done", done_cnt - d0, 0);

    // Restart from a new base after the abort
    push_bytes(32'hA1A2A3A4);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h8A);
`endif
    exp_addr_q.push_back(8'hFC);
    d0 = done_cnt;
    start_dump(8'hFC, 8'd1);
    wait_done("restart");
    check("restart_done_count", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_dump_streamer.md
# mem_dump_streamer

Reads 32-bit words out of the byte-addressable instruction/data memory through its asynchronous read port and streams them, one byte at a time, MSB first, to the UART transmitter. It sits between the debug unit, which issues the dump command, and the memory/UART TX pair. It is the read-side counterpart of the loader path that fills the memory.

## Interface
- NB_DATA, 32, memory word width; only 32 is supported.
- NB_ADDR, 8, byte address width of the memory.
- NB_BYTE, 8, width of the TX data byte.

- clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  dump request pulse; sampled only in IDLE.
- i_base_addr  in  NB_ADDR  byte address of the first word; captured on accepted i_start.
- i_word_count  in  NB_ADDR  number of words to send; captured on accepted i_start.
- o_mem_addr  out  NB_ADDR  read address driven to the memory.
- i_mem_data  in  NB_DATA  combinational read data from the memory, bits [31:24] at o_mem_addr.
- o_tx_data  out  NB_BYTE  byte presented to the transmitter; stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle pulse that launches a byte transmission.
- i_tx_done  in  1  one-cycle pulse from the transmitter at the end of a byte.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, LATCH, SEND, WAIT, ADV, DONE (plus CSUM when configured).
- IDLE: i_start=1 captures the base address into the address register and i_word_count into the remaining-word counter. If the count is 0, go to DONE. Otherwise go to LATCH.
- LATCH: o_mem_addr = address register. i_mem_data is registered into the word register. Byte index is set to 0. Next state is SEND.
- SEND: o_tx_start=1 for exactly one cycle. o_tx_data = word byte[index], where index 0 selects bits [31:24]. Next state is WAIT.
- WAIT: hold o_tx_data. On i_tx_done, go to ADV.
- ADV, when index<3: increment index and go to SEND.
- ADV, when index=3: decrement the remaining-word counter and add 4 to the address, modulo 2^NB_ADDR. If the counter reaches 0, go to DONE (or CSUM when configured). Otherwise go to LATCH.
- DONE: o_done=1 for one cycle, then go to IDLE.
- i_start while busy is ignored and not queued.
- i_tx_done outside WAIT is ignored.
- Address wrap: 0xFC+4 becomes 0x00. There is no error flag.

## Timing
- Reset values: o_mem_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0, state=IDLE. All counters are cleared.
- Reset asserted mid-dump aborts the dump on the next edge. No o_done is produced.
- First o_tx_start is 3 cycles after the i_start edge (IDLE→LATCH→SEND, pulse during SEND).
- Each byte costs 3 cycles plus the transmitter time (SEND, WAIT…, ADV). A word boundary adds 1 cycle for LATCH.
- o_busy rises the cycle after i_start is accepted. It falls the cycle after the o_done pulse.
- Memory data is sampled only in LATCH. Memory writes during a dump affect only words not yet latched.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - After the last data byte, state CSUM sends one extra byte, using the same SEND/WAIT handshake.
  - The extra byte is the 8-bit two's-complement sum, modulo 256, of all data bytes sent.
  - The sum register clears on accepted i_start.
  - With i_word_count=0, the checksum byte 0x00 is sent.
- DUMP_CHECKSUM_EN undefined: no CSUM state, no sum register. ADV goes directly to DONE.

## Test plan
- Reset with i_rst_n=0 for 2 cycles → all outputs 0, o_busy=0. After reset, i_tx_done pulses produce no o_tx_start.
- Memory 0x10..0x17 = 11 22 33 44 55 66 77 88, base=0x10, count=2, transmitter answers i_tx_done 5 cycles after each start → bytes 11,22,33,44,55,66,77,88 in order. Exactly one o_done. With checksum enabled, a ninth byte 0x64.
- count=0 → o_done 2 cycles after i_start, no o_tx_start. With checksum enabled, a single byte 0x00 is sent, then o_done.
- base=0xFC, count=2 → o_mem_addr is 0xFC, then 0x00. Bytes come from both addresses.
- i_start pulsed again in the middle of the dump, and i_tx_done pulsed during SEND → both ignored; byte sequence and count unchanged.
- i_rst_n=0 asserted after the 3rd byte → next cycle state is IDLE and outputs are 0, no o_done. A new i_start afterwards restarts from the new base.
